// File: rtl/serial_subtractor_4bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_4bit_if
//  Description : Request/result bundle for the bit-serial subtractor.
//                The master issues start with operands. The slave returns
//                the difference, the borrow and overflow flags, and the
//                busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_subtractor_4bit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic [WIDTH-1:0] d;
  logic             b_out;
  logic             v;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, b_in,
    input  d, b_out, v, busy, done
  );

  modport slave (
    input  start, a, b, b_in,
    output d, b_out, v, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_4bit
//  Description : Bit-serial subtractor that computes d = a - b - b_in,
//                LSB first, one bit per clock. It uses one full-subtractor
//                cell and a borrow flop. The result, borrow-out and signed
//                overflow are published together with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  wire                      clk,
  input  wire                      rst,
  serial_subtractor_4bit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_d;
  logic             r_b_out;
  logic             r_v;

  logic             w_diff;
  logic             w_brw_next;
  logic [WIDTH-1:0] w_d_next;
  logic             w_last;

  // Full-subtractor cell on the current LSBs, plus the shifted partial result
  always_comb begin
    w_diff     = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
    w_brw_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_brw);
    w_d_next   = {w_diff, r_d_sh[WIDTH-1:1]};
    w_last     = (r_cnt == C_LAST_BIT);
  end

  // Control FSM and datapath; a reset abandons any operation without a done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_d_sh  <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_d     <= '0;
      r_b_out <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_d_sh  <= '0;
            r_brw   <= bus.b_in;
            r_cnt   <= '0;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_d_sh <= w_d_next;
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_brw  <= w_brw_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            // Overflow uses the operand MSBs latched at start, because the shift registers no longer hold them
            r_d     <= w_d_next;
            r_b_out <= w_brw_next;
            r_v     <= (r_a_msb ^ r_b_msb) & (w_d_next[WIDTH-1] ^ r_a_msb);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.d     = r_d;
  assign bus.b_out = r_b_out;
  assign bus.v     = r_v;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_4bit
//  Description : Scoreboard bench for serial_subtractor_4bit (WIDTH=4).
//                The stimulus pushes expected results and a monitor pops
//                them on each done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor_4bit;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             v;
  } exp_t;

  logic clk;
  logic rst;

  serial_subtractor_4bit_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   done_count = 0;
  int   ops_issued = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      done_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_d",     int'(bus.d),     int'(e.d));
        check("sb_b_out", int'(bus.b_out), int'(e.b_out));
        check("sb_v",     int'(bus.v),     int'(e.v));
      end
    end
  end

  // Pulse start for one cycle at a negedge and leave the operands on the bus
  task automatic pulse_start(input logic [3:0] a, input logic [3:0] b, input logic bin);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.b_in  = bin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait for done with a cycle budget. Optionally check that done arrives exactly WIDTH cycles after acceptance
  task automatic wait_done(input bit chk_lat);
    int k = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done (t=%0t)", k, $time);
      exp_q.delete();
    end else if (chk_lat) begin
      check("latency", k, WIDTH);
    end
  endtask

  // Directed operation with hand-computed expected result
  task automatic op_directed(input logic [3:0] a, input logic [3:0] b, input logic bin,
                             input logic [3:0] ed, input logic eb, input logic ev);
    exp_t e;
    e.d = ed; e.b_out = eb; e.v = ev;
    exp_q.push_back(e);
    ops_issued++;
    pulse_start(a, b, bin);
    check("busy_in_run", int'(bus.busy), 1);
    wait_done(1'b1);
  endtask

  // Operation checked against a plain arithmetic model
  task automatic op_model(input logic [3:0] a, input logic [3:0] b, input logic bin);
    exp_t e;
    int   diff;
    diff      = int'(a) - int'(b) - int'(bin);
    e.d       = 4'(diff);
    e.b_out   = (diff < 0);
    e.v       = (a[3] ^ b[3]) & (e.d[3] ^ a[3]);
    exp_q.push_back(e);
    ops_issued++;
    pulse_start(a, b, bin);
    wait_done(1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.b_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_d",     int'(bus.d),     0);
    check("rst_b_out", int'(bus.b_out), 0);
    check("rst_v",     int'(bus.v),     0);
    check("rst_busy",  int'(bus.busy),  0);
    check("rst_done",  int'(bus.done),  0);
    rst = 1'b0;

    op_directed(4'd8, 4'd8, 1'b0, 4'h0, 1'b0, 1'b0);
    op_directed(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0);
    op_directed(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    op_directed(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1);
    op_directed(4'd7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);

    // Start pulsed mid-operation with new operands must be ignored
    begin
      exp_t e;
      e.d = 4'h7; e.b_out = 1'b0; e.v = 1'b1;
      exp_q.push_back(e);
      ops_issued++;
      pulse_start(4'd9, 4'd2, 1'b0);
      @(negedge clk);
      bus.a     = 4'd1;
      bus.b     = 4'd1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(1'b0);
      repeat (6) @(negedge clk);
      check("hold_d_idle", int'(bus.d), 7);
      check("idle_busy",   int'(bus.busy), 0);
    end

    // Reset during RUN abandons the operation: no done, outputs cleared
    pulse_start(4'd9, 4'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_d",     int'(bus.d),     0);
    check("mid_rst_b_out", int'(bus.b_out), 0);
    check("mid_rst_v",     int'(bus.v),     0);
    check("mid_rst_busy",  int'(bus.busy),  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    op_directed(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0);

    for (int bi = 0; bi < 2; bi++)
      for (int ai = 0; ai < 16; ai++)
        for (int bb = 0; bb < 16; bb++)
          op_model(4'(ai), 4'(bb), 1'(bi));

    repeat (4) @(negedge clk);
    check("done_count",     done_count, ops_issued);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
